// File: rtl/mod_mul_arb.sv
// rtl/mod_mul_arb.sv - two-port arbiter and two-stage pipeline around a shared mod_mul
// Define MOD_MUL_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module mod_mul (
    input  logic [22:0] a_i,
    input  logic [22:0] b_i,
    input  logic        sel_i,
    output logic [22:0] c_o
);
    localparam logic [23:0] Q_D = 24'd8380417;
    localparam logic [13:0] Q_K = 14'd3329;
    localparam logic [83:0] K_M = (84'd1 << 48) / 84'd3329;

    logic [45:0] prod;
    logic [36:0] d_f1;
    logic [27:0] d_f2;
    logic [23:0] d_f3;
    logic [22:0] d_c;
    logic [83:0] k_qm;
    logic [35:0] k_t;
    logic [83:0] k_diff;
    logic [13:0] k_r;
    logic [11:0] k_c;

    always_comb begin
        prod   = 46'(a_i) * 46'(b_i);
        // q_d = 2^23 - 2^13 + 1, so each 2^23 weight folds down to 2^13 - 1
        d_f1   = 37'(prod[22:0]) + 37'(prod[45:23]) * 37'd8191;
        d_f2   = 28'(d_f1[22:0]) + 28'(d_f1[36:23]) * 28'd8191;
        d_f3   = 24'(d_f2[22:0]) + 24'(d_f2[27:23]) * 24'd8191;
        d_c    = (d_f3 >= Q_D) ? 23'(d_f3 - Q_D) : d_f3[22:0];
        // Barrett with a 2^48 scale leaves the remainder below 2*q_k
        k_qm   = 84'(prod) * K_M;
        k_t    = 36'(k_qm >> 48);
        k_diff = 84'(prod) - 84'(k_t) * 84'(Q_K);
        k_r    = 14'(k_diff);
        k_c    = (k_r >= Q_K) ? 12'(k_r - Q_K) : k_r[11:0];
        c_o    = sel_i ? d_c : {11'd0, k_c};
    end
endmodule

module mod_mul_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [22:0]      req_a0_i,
    input  logic [22:0]      req_b0_i,
    input  logic [22:0]      req_a1_i,
    input  logic [22:0]      req_b1_i,
    input  logic [1:0]       req_sel_i,
    input  logic [TAG_W-1:0] req_tag0_i,
    input  logic [TAG_W-1:0] req_tag1_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [22:0]      rsp_c_o
);
    logic             s1_valid_q, s1_valid_d;
    logic [22:0]      s1_a_q, s1_a_d;
    logic [22:0]      s1_b_q, s1_b_d;
    logic             s1_sel_q, s1_sel_d;
    logic             s1_id_q, s1_id_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [22:0]      s2_c_q, s2_c_d;
    logic             s2_id_q, s2_id_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic [1:0]       grant;
    logic             s1_adv;
    logic             s2_adv;
    logic [22:0]      mm_c;

`ifdef MOD_MUL_ARB_RR_EN
    logic             last_q, last_d;
`endif

    mod_mul u_mod_mul (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .sel_i (s1_sel_q),
        .c_o   (mm_c)
    );

    always_comb begin
        s2_adv = !s2_valid_q || rsp_ready_i;
        s1_adv = !s1_valid_q || s2_adv;
`ifdef MOD_MUL_ARB_RR_EN
        if (req_valid_i == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = req_valid_i;
        end
`else
        grant = {req_valid_i[1] & ~req_valid_i[0], req_valid_i[0]};
`endif
    end

    assign req_ready_o = grant & {2{s1_adv}};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sel_d   = s1_sel_q;
        s1_id_d    = s1_id_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_c_d     = s2_c_q;
        s2_id_d    = s2_id_q;
        s2_tag_d   = s2_tag_q;
`ifdef MOD_MUL_ARB_RR_EN
        last_d     = last_q;
        if (|req_ready_o) begin
            last_d = req_ready_o[1];
        end
`endif
        // S2 moves only when its slot frees, so an empty S1 never overwrites a held response
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_c_d     = mm_c;
            s2_id_d    = s1_id_q;
            s2_tag_d   = s1_tag_q;
        end
        if (s1_adv) begin
            s1_valid_d = |grant;
            if (grant[1]) begin
                s1_a_d   = req_a1_i;
                s1_b_d   = req_b1_i;
                s1_sel_d = req_sel_i[1];
                s1_id_d  = 1'b1;
                s1_tag_d = req_tag1_i;
            end else if (grant[0]) begin
                s1_a_d   = req_a0_i;
                s1_b_d   = req_b0_i;
                s1_sel_d = req_sel_i[0];
                s1_id_d  = 1'b0;
                s1_tag_d = req_tag0_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sel_q   <= 1'b0;
            s1_id_q    <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_c_q     <= '0;
            s2_id_q    <= 1'b0;
            s2_tag_q   <= '0;
`ifdef MOD_MUL_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sel_q   <= s1_sel_d;
            s1_id_q    <= s1_id_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_c_q     <= s2_c_d;
            s2_id_q    <= s2_id_d;
            s2_tag_q   <= s2_tag_d;
`ifdef MOD_MUL_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign rsp_valid_o = s2_valid_q;
    assign rsp_id_o    = s2_id_q;
    assign rsp_tag_o   = s2_tag_q;
    assign rsp_c_o     = s2_c_q;
endmodule

// File: tb/tb_mod_mul_arb.sv
// tb/tb_mod_mul_arb.sv - self-checking bench for mod_mul_arb with a queue-based reference model
`timescale 1ns/1ps

module tb_mod_mul_arb;
    localparam int TAG_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [1:0]       req_valid_i = 2'b00;
    logic [1:0]       req_ready_o;
    logic [22:0]      req_a0_i = '0, req_b0_i = '0, req_a1_i = '0, req_b1_i = '0;
    logic [1:0]       req_sel_i = 2'b00;
    logic [TAG_W-1:0] req_tag0_i = '0, req_tag1_i = '0;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b1;
    logic             rsp_id_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [22:0]      rsp_c_o;

    always #5 clk_i = ~clk_i;

    mod_mul_arb #(.TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a0_i(req_a0_i), .req_b0_i(req_b0_i),
        .req_a1_i(req_a1_i), .req_b1_i(req_b1_i),
        .req_sel_i(req_sel_i), .req_tag0_i(req_tag0_i), .req_tag1_i(req_tag1_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_tag_o(rsp_tag_o), .rsp_c_o(rsp_c_o)
    );

    typedef struct { logic [22:0] a; logic [22:0] b; logic sel; logic [TAG_W-1:0] tag; } req_t;
    typedef struct { logic [22:0] c; logic id; logic [TAG_W-1:0] tag; int rdy; } exp_t;
    typedef struct { logic id; logic [TAG_W-1:0] tag; logic [22:0] c; int cyc; } log_t;

    req_t q0[$];
    req_t q1[$];
    exp_t mq[$];
    log_t acc_log[$];
    log_t rsp_log[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
`ifdef MOD_MUL_ARB_RR_EN
    logic m_last = 1'b1;
    localparam logic [3:0] CONT_IDS = 4'b1010;
`else
    localparam logic [3:0] CONT_IDS = 4'b0000;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [22:0] ref_mul(input logic [22:0] a, input logic [22:0] b, input logic sel);
        logic [63:0] p;
        p = {41'd0, a} * {41'd0, b};
        if (sel) return 23'(p % 64'd8380417);
        return 23'(p % 64'd3329);
    endfunction

    // Model: in-flight requests form a FIFO of capacity two; each becomes visible two cycles
    // after acceptance, or one cycle after its predecessor leaves, whichever is later.
    always @(negedge clk_i) begin : cmp
        logic [1:0] g;
        logic [1:0] exp_rdy;
        logic       exp_vld;
        exp_t       e;
        if (rst_i) begin
            mq.delete();
`ifdef MOD_MUL_ARB_RR_EN
            m_last = 1'b1;
`endif
        end else begin
            if (req_valid_i == 2'b11) begin
`ifdef MOD_MUL_ARB_RR_EN
                g = m_last ? 2'b01 : 2'b10;
`else
                g = 2'b01;
`endif
            end else begin
                g = req_valid_i;
            end
            exp_rdy = (mq.size() < 2 || rsp_ready_i) ? g : 2'b00;
            exp_vld = (mq.size() > 0) && (mq[0].rdy <= cyc);
            chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
            chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_vld));
            if (exp_vld) begin
                chk("rsp_c", 64'(rsp_c_o), 64'(mq[0].c));
                chk("rsp_id", 64'(rsp_id_o), 64'(mq[0].id));
                chk("rsp_tag", 64'(rsp_tag_o), 64'(mq[0].tag));
            end
            if (rsp_valid_o && rsp_ready_i)
                rsp_log.push_back('{rsp_id_o, rsp_tag_o, rsp_c_o, cyc});
            if (|(req_ready_o & req_valid_i))
                acc_log.push_back('{req_ready_o[1], req_ready_o[1] ? req_tag1_i : req_tag0_i, 23'd0, cyc});
            if (exp_vld && rsp_ready_i) begin
                void'(mq.pop_front());
                if (mq.size() > 0 && mq[0].rdy < cyc + 1) mq[0].rdy = cyc + 1;
            end
            if (|exp_rdy) begin
                e.id  = exp_rdy[1];
                e.tag = exp_rdy[1] ? req_tag1_i : req_tag0_i;
                e.c   = exp_rdy[1] ? ref_mul(req_a1_i, req_b1_i, req_sel_i[1])
                                   : ref_mul(req_a0_i, req_b0_i, req_sel_i[0]);
                e.rdy = cyc + 2;
                mq.push_back(e);
`ifdef MOD_MUL_ARB_RR_EN
                m_last = exp_rdy[1];
`endif
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_req(input int port, input int a, input int b, input logic sel, input int tag);
        req_t r;
        r.a = 23'(a); r.b = 23'(b); r.sel = sel; r.tag = TAG_W'(tag);
        if (port == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        rsp_log.delete();
    endtask

    // Presents queued requests, advancing each port only on acceptance; rsp_ready held low for hold cycles.
    task automatic run_stream(input int hold);
        int k;
        logic [1:0] r;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
            req_valid_i = {q1.size() != 0, q0.size() != 0};
            if (q0.size() != 0) begin
                req_a0_i = q0[0].a; req_b0_i = q0[0].b; req_sel_i[0] = q0[0].sel; req_tag0_i = q0[0].tag;
            end
            if (q1.size() != 0) begin
                req_a1_i = q1[0].a; req_b1_i = q1[0].b; req_sel_i[1] = q1[0].sel; req_tag1_i = q1[0].tag;
            end
            rsp_ready_i = (k >= hold);
            @(negedge clk_i);
            #1;
            r = req_ready_o;
            step();
            if (r[0]) void'(q0.pop_front());
            if (r[1]) void'(q1.pop_front());
            k++;
        end
        if (k >= 200) begin
            bound_fail("stream_accept");
            q0.delete();
            q1.delete();
        end
        req_valid_i = 2'b00;
        rsp_ready_i = 1'b1;
        k = 0;
        while (mq.size() != 0 && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) bound_fail("stream_drain");
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        repeat (3) step();
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id_o), 64'd0);
        chk("reset_rsp_tag", 64'(rsp_tag_o), 64'd0);
        chk("reset_rsp_c", 64'(rsp_c_o), 64'd0);
        rst_i = 1'b0;
        step();

        // contention: both requesters stream four requests each
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            push_req(0, i + 1, 7, 1'b0, i);
            push_req(1, 100 + i, 2, 1'b1, 8 + i);
        end
        run_stream(0);
        chk("cont_acc_count", 64'(acc_log.size()), 64'd8);
        chk("cont_rsp_count", 64'(rsp_log.size()), 64'd8);
        if (acc_log.size() >= 4 && rsp_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("cont_grant_id", 64'(acc_log[i].id), 64'(CONT_IDS[i]));
                chk("cont_rsp_id", 64'(rsp_log[i].id), 64'(CONT_IDS[i]));
            end
        end

        // single request latency and value
        clear_logs();
        push_req(0, 3, 5, 1'b0, 'hA);
        run_stream(0);
        chk("single_acc_count", 64'(acc_log.size()), 64'd1);
        chk("single_rsp_count", 64'(rsp_log.size()), 64'd1);
        if (acc_log.size() == 1 && rsp_log.size() == 1) begin
            chk("single_latency", 64'(rsp_log[0].cyc - acc_log[0].cyc), 64'd2);
            chk("single_c", 64'(rsp_log[0].c), 64'd15);
            chk("single_id", 64'(rsp_log[0].id), 64'd0);
            chk("single_tag", 64'(rsp_log[0].tag), 64'hA);
        end

        // backpressure: four from requester 1 with the response side stalled for five cycles
        clear_logs();
        for (int i = 0; i < 4; i++) push_req(1, 1000 + i, 3, 1'b1, i + 1);
        run_stream(5);
        chk("bp_acc_count", 64'(acc_log.size()), 64'd4);
        chk("bp_rsp_count", 64'(rsp_log.size()), 64'd4);
        if (acc_log.size() == 4 && rsp_log.size() == 4) begin
            chk("bp_acc1_gap", 64'(acc_log[1].cyc - acc_log[0].cyc), 64'd1);
            chk("bp_acc2_gap", 64'(acc_log[2].cyc - acc_log[0].cyc), 64'd5);
            chk("bp_acc3_gap", 64'(acc_log[3].cyc - acc_log[0].cyc), 64'd6);
            for (int i = 0; i < 4; i++) begin
                chk("bp_rsp_tag", 64'(rsp_log[i].tag), 64'(i + 1));
                chk("bp_rsp_c", 64'(rsp_log[i].c), 64'((1000 + i) * 3));
                if (i > 0) chk("bp_rsp_back2back", 64'(rsp_log[i].cyc - rsp_log[i-1].cyc), 64'd1);
            end
        end

        // D and K reduction of (q_d - 1)^2
        clear_logs();
        push_req(0, 8380416, 8380416, 1'b1, 3);
        push_req(0, 8380416, 8380416, 1'b0, 4);
        run_stream(0);
        chk("dmode_rsp_count", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() == 2) begin
            chk("dmode_c", 64'(rsp_log[0].c), 64'd1);
            chk("kmode_c", 64'(rsp_log[1].c), 64'd2604);
            chk("kmode_high_zero", 64'(rsp_log[1].c[22:12]), 64'd0);
        end

        // idle
        req_valid_i = 2'b00;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
            chk("idle_req_ready", 64'(req_ready_o), 64'd0);
        end

        // reset with S1 and S2 both occupied
        rsp_ready_i = 1'b0;
        req_valid_i = 2'b01;
        req_a0_i = 23'd11; req_b0_i = 23'd13; req_sel_i = 2'b00; req_tag0_i = 4'd5;
        step();
        req_a0_i = 23'd17; req_tag0_i = 4'd6;
        step();
        req_valid_i = 2'b00;
        chk("pre_reset_rsp_valid", 64'(rsp_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        step();
        step();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        clear_logs();
        repeat (5) step();
        chk("post_reset_no_stale", 64'(rsp_log.size()), 64'd0);
        push_req(0, 2, 2, 1'b0, 1);
        push_req(1, 4, 4, 1'b0, 2);
        run_stream(0);
        chk("post_reset_acc_count", 64'(acc_log.size()), 64'd2);
        if (acc_log.size() >= 1) chk("post_reset_first_grant", 64'(acc_log[0].id), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
